// File: rtl/toggle_dec_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_dec_pkg
//  Purpose  : Shared FSM state encoding and default parameter values for
//             toggle_event_decoder and its synchronizer sub-module.
//  Revision : 1.0  initial release
// ============================================================================
package toggle_dec_pkg;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_FILTER_LEN  = 3;

  // Fixed encodings kept as plain constants so legacy code can compare bits
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    INIT = ST_INIT,
    RUN  = ST_RUN
  } state_e;

endpackage : toggle_dec_pkg
`default_nettype wire

// File: rtl/toggle_sync_chain.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_sync_chain
//  Purpose  : STAGES-deep flop chain bringing an asynchronous level into the
//             clk domain. Asynchronous active-low reset clears every stage.
//  Revision : 1.0  initial release
// ============================================================================
module toggle_sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the chain, oldest sample at the MSB
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : toggle_sync_chain
`default_nettype wire

// File: rtl/toggle_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_event_decoder
//  Purpose  : Receive side of toggle signalling. Synchronizes the toggle line,
//             turns each accepted level change into a one-cycle pulse, counts
//             events and keeps a pending/ack handshake with overflow flag.
//  Config   : TOGGLE_DEC_FILTER_EN - when defined, a level change must be seen
//             for FILTER_LEN consecutive cycles before it is accepted.
//  Revision : 1.0  initial release
// ============================================================================
module toggle_event_decoder
  import toggle_dec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic             clk,
  input  logic             asyncResetN,
  input  logic             toggleIn,
  input  logic             ack,
  input  logic             clear,
  output logic             level,
  output logic             pulse,
  output logic             pending,
  output logic             overflow,
  output logic [CNT_W-1:0] eventCount
);

  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
      (FILTER_LEN < 1) || (FILTER_LEN > 15)) begin : g_param_check
    $error("toggle_event_decoder: SYNC_STAGES or FILTER_LEN out of range");
  end

  // INIT spans SYNC_STAGES+1 edges: SYNC_STAGES to flush the chain, plus one
  // more so level is loaded from the first real sample. Leaving earlier would
  // compare against the chain's reset zeros and fake an event when the line
  // idles high.
  localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

  logic             w_sync;
  logic             w_diff;
  logic             w_flip;
  state_e           state_q, state_d;
  logic [2:0]       init_q, init_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  toggle_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_ni (asyncResetN),
    .d_i    (toggleIn),
    .q_o    (w_sync)
  );

  assign w_diff = (w_sync != level_q);

`ifdef TOGGLE_DEC_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

  logic [3:0] filt_q, filt_d;

  // Accept a change only after FILTER_LEN consecutive mismatching samples
  always_comb begin
    filt_d = '0;
    w_flip = 1'b0;
    if ((state_q == RUN) && w_diff) begin
      if (filt_q == FILT_LAST) begin
        w_flip = 1'b1;
      end else begin
        filt_d = filt_q + 4'd1;
      end
    end
  end

  // Filter run-length register
  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  // Without the filter every mismatch in RUN is an event
  always_comb begin
    w_flip = (state_q == RUN) && w_diff;
  end
`endif

  // FSM, accepted level and pulse strobe
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      INIT: begin
        level_d = w_sync;
        if (init_q == INIT_LAST) begin
          state_d = RUN;
        end else begin
          init_d = init_q + 3'd1;
        end
      end
      RUN: begin
        if (w_flip) begin
          level_d = ~level_q;
        end
        pulse_d = w_flip;
      end
      default: state_d = INIT;
    endcase
  end

  // Event counter and pending/overflow handshake; clear overrides events
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clear) begin
      cnt_d  = '0;
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (w_flip) begin
      cnt_d  = cnt_q + CNT_W'(1);
      pend_d = 1'b1;
      if (pend_q && !ack) begin
        ovf_d = 1'b1;
      end
    end else if (ack && pend_q) begin
      pend_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state_q <= INIT;
      init_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level      = level_q;
  assign pulse      = pulse_q;
  assign pending    = pend_q;
  assign overflow   = ovf_q;
  assign eventCount = cnt_q;

endmodule : toggle_event_decoder
`default_nettype wire
